// File: rtl/mcpu2_defs.sv
// Shared opcode field positions, location codes and FSM state encoding
// for the mcpu2 move-machine core.
package mcpu2_defs;

    localparam int OPC_IMM_BIT  = 7;
    localparam int OPC_COND_BIT = 6;
    localparam int OPC_DST_MSB  = 5;
    localparam int OPC_DST_LSB  = 3;
    localparam int OPC_SRC_MSB  = 2;
    localparam int OPC_SRC_LSB  = 0;

    localparam logic [7:0] OPC_HALT = 8'h00;

    typedef logic [2:0] loc_t;

    // Codes 3 and 4 name different things as source and as destination.
    localparam loc_t LOC_PC    = 3'd0;
    localparam loc_t LOC_ADDR  = 3'd1;
    localparam loc_t LOC_RAM   = 3'd2;
    localparam loc_t SRC_IMM   = 3'd3;
    localparam loc_t DST_ALU_A = 3'd3;
    localparam loc_t SRC_ALU   = 3'd4;
    localparam loc_t DST_ALU_B = 3'd4;
    localparam loc_t LOC_I     = 3'd5;
    localparam loc_t LOC_J     = 3'd6;
    localparam loc_t LOC_K     = 3'd7;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MEM  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    function automatic loc_t instr_dst(input logic [7:0] instr);
        return instr[OPC_DST_MSB:OPC_DST_LSB];
    endfunction

    function automatic loc_t instr_src(input logic [7:0] instr);
        return instr[OPC_SRC_MSB:OPC_SRC_LSB];
    endfunction

endpackage

// File: rtl/mcpu2_core_if.sv
// Bus bundle between the mcpu2 core and its instruction ROM, data RAM and ALU.
interface mcpu2_core_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] cnt_pc;
    logic [7:0]            irom_in;
    logic                  irom_valid;
    logic [DATA_WIDTH-1:0] dram_addr;
    logic [DATA_WIDTH-1:0] dram_wdata;
    logic [DATA_WIDTH-1:0] dram_rdata;
    logic                  dram_re;
    logic                  dram_we;
    logic                  dram_ack;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [DATA_WIDTH-1:0] alu_op;
    logic [DATA_WIDTH-1:0] alu_d;
    logic                  alu_f;
    logic                  halted;

    modport master (
        output cnt_pc,
        input  irom_in, irom_valid,
        output dram_addr, dram_wdata, dram_re, dram_we,
        input  dram_rdata, dram_ack,
        output alu_a, alu_b, alu_op,
        input  alu_d, alu_f,
        output halted
    );

    modport slave (
        input  cnt_pc,
        output irom_in, irom_valid,
        input  dram_addr, dram_wdata, dram_re, dram_we,
        output dram_rdata, dram_ack,
        input  alu_a, alu_b, alu_op,
        output alu_d, alu_f,
        input  halted
    );

endinterface

// File: rtl/mcpu2_decode.sv
// Combinational instruction decode: field split, condition evaluation,
// memory-operation and halt detection.
module mcpu2_decode
    import mcpu2_defs::*;
(
    input  logic [7:0] instr,
    input  logic       alu_f,
    output logic       is_imm,
    output logic [6:0] imm7,
    output loc_t       dst,
    output loc_t       src,
    output logic       execute,
    output logic       mem_op,
    output logic       halt
);

    assign is_imm  = instr[OPC_IMM_BIT];
    assign imm7    = instr[6:0];
    assign dst     = instr_dst(instr);
    assign src     = instr_src(instr);
    assign halt    = (instr == OPC_HALT);
    // A conditional move only fires when the ALU flag is set.
    assign execute = !is_imm && (!instr[OPC_COND_BIT] || alu_f);
    assign mem_op  = execute && ((src == LOC_RAM) || (dst == LOC_RAM));

endmodule

// File: rtl/mcpu2_core.sv
// mcpu2 move-machine core: register file, PC and RUN/MEM/HALT sequencer.
// Every instruction is a move between locations, or an immediate load.
module mcpu2_core
    import mcpu2_defs::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic           clk,
    input  logic           reset,
    mcpu2_core_if.master   bus
);

    typedef logic [DATA_WIDTH-1:0] word_t;
    localparam word_t ONE = word_t'(1'b1);

    state_t state_r, state_s;
    word_t  pc_r, pc_s;
    word_t  addr_r, addr_s;
    word_t  imm_r, imm_s;
    word_t  alu_a_r, alu_a_s;
    word_t  alu_b_r, alu_b_s;
    word_t  i_r, i_s;
    word_t  j_r, j_s;
    word_t  k_r, k_s;
    logic   last_imm_r, last_imm_s;
    logic   halted_r, halted_s;
    word_t  dram_addr_r, dram_addr_s;
    word_t  dram_wdata_r, dram_wdata_s;
    logic   dram_re_r, dram_re_s;
    logic   dram_we_r, dram_we_s;
    loc_t   mem_dst_r, mem_dst_s;
    logic   mem_src_ram_r, mem_src_ram_s;

    logic       dec_is_imm_s;
    logic [6:0] dec_imm7_s;
    loc_t       dec_dst_s;
    loc_t       dec_src_s;
    logic       dec_execute_s;
    logic       dec_mem_op_s;
    logic       dec_halt_s;

    word_t src_val_s;
    logic  wr_en_s;
    loc_t  wr_dst_s;
    word_t wr_val_s;

    mcpu2_decode u_decode (
        .instr   (bus.irom_in),
        .alu_f   (bus.alu_f),
        .is_imm  (dec_is_imm_s),
        .imm7    (dec_imm7_s),
        .dst     (dec_dst_s),
        .src     (dec_src_s),
        .execute (dec_execute_s),
        .mem_op  (dec_mem_op_s),
        .halt    (dec_halt_s)
    );

    // Source operand selection for the instruction being decoded
    always_comb begin
        src_val_s = '0;
        case (dec_src_s)
            LOC_PC:   src_val_s = pc_r;
            LOC_ADDR: src_val_s = addr_r;
            LOC_RAM:  src_val_s = '0;
            SRC_IMM:  src_val_s = imm_r;
            SRC_ALU:  src_val_s = bus.alu_d;
            LOC_I:    src_val_s = i_r;
            LOC_J:    src_val_s = j_r;
            LOC_K:    src_val_s = k_r;
            default:  src_val_s = '0;
        endcase
    end

    // Next-state, PC, request and register-file write computation
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        imm_s         = imm_r;
        last_imm_s    = last_imm_r;
        halted_s      = halted_r;
        dram_addr_s   = dram_addr_r;
        dram_wdata_s  = dram_wdata_r;
        dram_re_s     = dram_re_r;
        dram_we_s     = dram_we_r;
        mem_dst_s     = mem_dst_r;
        mem_src_ram_s = mem_src_ram_r;
        addr_s        = addr_r;
        alu_a_s       = alu_a_r;
        alu_b_s       = alu_b_r;
        i_s           = i_r;
        j_s           = j_r;
        k_s           = k_r;
        wr_en_s       = 1'b0;
        wr_dst_s      = LOC_PC;
        wr_val_s      = '0;

        case (state_r)
            ST_RUN: begin
                if (!bus.irom_valid) begin
                    state_s = ST_RUN;
                end else if (dec_halt_s) begin
                    state_s    = ST_HALT;
                    halted_s   = 1'b1;
                    last_imm_s = 1'b0;
                end else if (dec_is_imm_s) begin
                    // Consecutive IMMs build wide constants 7 bits at a time.
                    if (last_imm_r) begin
                        imm_s = {imm_r[DATA_WIDTH-8:0], dec_imm7_s};
                    end else begin
                        imm_s = {{(DATA_WIDTH-7){1'b0}}, dec_imm7_s};
                    end
                    last_imm_s = 1'b1;
                    pc_s       = pc_r + ONE;
                end else begin
                    last_imm_s = 1'b0;
                    if (!dec_execute_s) begin
                        pc_s = pc_r + ONE;
                    end else if (dec_mem_op_s) begin
                        state_s       = ST_MEM;
                        dram_addr_s   = addr_r;
                        dram_re_s     = (dec_src_s == LOC_RAM);
                        dram_we_s     = (dec_dst_s == LOC_RAM) && (dec_src_s != LOC_RAM);
                        dram_wdata_s  = src_val_s;
                        mem_dst_s     = dec_dst_s;
                        mem_src_ram_s = (dec_src_s == LOC_RAM);
                    end else begin
                        wr_en_s  = 1'b1;
                        wr_dst_s = dec_dst_s;
                        wr_val_s = src_val_s;
                        pc_s     = (dec_dst_s == LOC_PC) ? src_val_s : pc_r + ONE;
                    end
                end
            end
            ST_MEM: begin
                if (bus.dram_ack) begin
                    state_s   = ST_RUN;
                    dram_re_s = 1'b0;
                    dram_we_s = 1'b0;
                    wr_en_s   = mem_src_ram_r;
                    wr_dst_s  = mem_dst_r;
                    wr_val_s  = bus.dram_rdata;
                    if (mem_src_ram_r && (mem_dst_r == LOC_PC)) begin
                        pc_s = bus.dram_rdata;
                    end else begin
                        pc_s = pc_r + ONE;
                    end
                end else begin
                    state_s = ST_MEM;
                end
            end
            ST_HALT: begin
                state_s = ST_HALT;
            end
            default: begin
                state_s = ST_RUN;
            end
        endcase

        // PC and RAM destinations are handled above; they fall to default.
        if (wr_en_s) begin
            case (wr_dst_s)
                LOC_ADDR:  addr_s  = wr_val_s;
                DST_ALU_A: alu_a_s = wr_val_s;
                DST_ALU_B: alu_b_s = wr_val_s;
                LOC_I:     i_s     = wr_val_s;
                LOC_J:     j_s     = wr_val_s;
                LOC_K:     k_s     = wr_val_s;
                default:   addr_s  = addr_r;
            endcase
        end else begin
            addr_s = addr_r;
        end
    end

    // State and register update with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_RUN;
            pc_r          <= RESET_PC;
            addr_r        <= '0;
            imm_r         <= '0;
            alu_a_r       <= '0;
            alu_b_r       <= '0;
            i_r           <= '0;
            j_r           <= '0;
            k_r           <= '0;
            last_imm_r    <= 1'b0;
            halted_r      <= 1'b0;
            dram_addr_r   <= '0;
            dram_wdata_r  <= '0;
            dram_re_r     <= 1'b0;
            dram_we_r     <= 1'b0;
            mem_dst_r     <= LOC_PC;
            mem_src_ram_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            addr_r        <= addr_s;
            imm_r         <= imm_s;
            alu_a_r       <= alu_a_s;
            alu_b_r       <= alu_b_s;
            i_r           <= i_s;
            j_r           <= j_s;
            k_r           <= k_s;
            last_imm_r    <= last_imm_s;
            halted_r      <= halted_s;
            dram_addr_r   <= dram_addr_s;
            dram_wdata_r  <= dram_wdata_s;
            dram_re_r     <= dram_re_s;
            dram_we_r     <= dram_we_s;
            mem_dst_r     <= mem_dst_s;
            mem_src_ram_r <= mem_src_ram_s;
        end
    end

    assign bus.cnt_pc     = pc_r;
    assign bus.dram_addr  = dram_addr_r;
    assign bus.dram_wdata = dram_wdata_r;
    assign bus.dram_re    = dram_re_r;
    assign bus.dram_we    = dram_we_r;
    assign bus.alu_a      = alu_a_r;
    assign bus.alu_b      = alu_b_r;
    assign bus.alu_op     = imm_r;
    assign bus.halted     = halted_r;

endmodule

// File: tb/tb_mcpu2_core.sv
// Bench for mcpu2_core: constant vector table, directed corner sequences and
// random programs checked against an instruction-level reference model.
module tb_mcpu2_core;
    import mcpu2_defs::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mcpu2_core_if #(.DATA_WIDTH(32)) bus ();

    mcpu2_core #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference architectural state
    logic [31:0] m_pc, m_addr, m_imm, m_alu_a, m_alu_b, m_i, m_j, m_k;
    logic        m_last, m_halt;

    typedef struct {
        logic        rst;
        logic [7:0]  ins;
        logic        f;
        int          sel;
        logic [31:0] exp_val;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        m_pc = 32'h0; m_addr = 32'h0; m_imm = 32'h0; m_alu_a = 32'h0; m_alu_b = 32'h0;
        m_i = 32'h0; m_j = 32'h0; m_k = 32'h0; m_last = 1'b0; m_halt = 1'b0;
    endtask

    function automatic logic [31:0] m_src(input logic [2:0] c);
        case (c)
            3'd0:    return m_pc;
            3'd1:    return m_addr;
            3'd3:    return m_imm;
            3'd4:    return bus.alu_d;
            3'd5:    return m_i;
            3'd6:    return m_j;
            3'd7:    return m_k;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_write(input logic [2:0] d, input logic [31:0] v);
        case (d)
            3'd1:    m_addr  = v;
            3'd3:    m_alu_a = v;
            3'd4:    m_alu_b = v;
            3'd5:    m_i     = v;
            3'd6:    m_j     = v;
            3'd7:    m_k     = v;
            default: m_addr  = m_addr;
        endcase
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, ".pc"},     bus.cnt_pc, m_pc);
        chk({tag, ".imm"},    bus.alu_op, m_imm);
        chk({tag, ".alu_a"},  bus.alu_a,  m_alu_a);
        chk({tag, ".alu_b"},  bus.alu_b,  m_alu_b);
        chk({tag, ".addr"},   dut.addr_r, m_addr);
        chk({tag, ".i"},      dut.i_r,    m_i);
        chk({tag, ".j"},      dut.j_r,    m_j);
        chk({tag, ".k"},      dut.k_r,    m_k);
        chk({tag, ".halted"}, {31'd0, bus.halted}, {31'd0, m_halt});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.irom_valid = 1'b0;
        bus.dram_ack = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        m_reset();
    endtask

    // Present one instruction, service any RAM transaction, update the model.
    task automatic run_instr(input logic [7:0] ins, input logic f, input int lat,
                             input logic [31:0] rd, output int held);
        logic [2:0]  s, d;
        logic        exe, mem, src_ram, dst_ram;
        logic [31:0] v;
        held = 0;
        s = ins[2:0];
        d = ins[5:3];
        src_ram = (s == 3'd2);
        dst_ram = (d == 3'd2);
        exe = !m_halt && (ins != 8'h00) && !ins[7] && (!ins[6] || f);
        mem = exe && (src_ram || dst_ram);
        bus.irom_in = ins;
        bus.irom_valid = 1'b1;
        bus.alu_f = f;
        bus.alu_d = $urandom();
        v = m_src(s);
        @(posedge clk); #1;
        bus.irom_valid = 1'b0;
        bus.irom_in = 8'($urandom());
        if (mem) begin
            for (int c = 1; c <= lat; c++) begin
                if (bus.dram_re || bus.dram_we) held++;
                chk("mem_req", {30'd0, bus.dram_re, bus.dram_we},
                    {30'd0, src_ram, dst_ram && !src_ram});
                chk("mem_addr", bus.dram_addr, m_addr);
                if (!src_ram) chk("mem_wdata", bus.dram_wdata, v);
                if (c == lat) begin
                    bus.dram_ack = 1'b1;
                    bus.dram_rdata = rd;
                end
                @(posedge clk); #1;
            end
            bus.dram_ack = 1'b0;
            chk("mem_done", {30'd0, bus.dram_re, bus.dram_we}, 32'd0);
        end else begin
            chk("no_req", {30'd0, bus.dram_re, bus.dram_we}, 32'd0);
        end
        if (m_halt) begin
            m_halt = 1'b1;
        end else if (ins == 8'h00) begin
            m_halt = 1'b1;
            m_last = 1'b0;
        end else if (ins[7]) begin
            m_imm  = m_last ? ((m_imm << 7) | {25'd0, ins[6:0]}) : {25'd0, ins[6:0]};
            m_last = 1'b1;
            m_pc   = m_pc + 32'd1;
        end else begin
            m_last = 1'b0;
            if (!exe) begin
                m_pc = m_pc + 32'd1;
            end else begin
                if (src_ram) v = rd;
                if (!dst_ram) m_write(d, v);
                m_pc = (d == 3'd0) ? v : m_pc + 32'd1;
            end
        end
        cmp_all("instr");
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            bus.irom_valid = 1'b0;
            bus.irom_in = 8'($urandom());
            bus.alu_f = 1'($urandom());
            bus.dram_ack = 1'($urandom());
            @(posedge clk); #1;
            chk("idle_req", {30'd0, bus.dram_re, bus.dram_we}, 32'd0);
        end
        bus.dram_ack = 1'b0;
        cmp_all("idle");
    endtask

    initial begin
        int held;
        logic [7:0] ins;
        logic [31:0] act;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.irom_in = 8'h00;
        bus.irom_valid = 1'b0;
        bus.dram_ack = 1'b0;
        bus.dram_rdata = 32'h0;
        bus.alu_d = 32'h0;
        bus.alu_f = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
        cmp_all("reset");
        chk("reset_req", {30'd0, bus.dram_re, bus.dram_we}, 32'd0);
        chk("reset_wdata", bus.dram_wdata, 32'h0);

        // Constant vectors: immediate chaining and conditional moves
        vt[0] = '{1'b1, 8'h81, 1'b0, 0, 32'h01, 32'd1};
        vt[1] = '{1'b0, 8'hFF, 1'b0, 0, 32'hFF, 32'd2};
        vt[2] = '{1'b0, 8'h2B, 1'b0, 1, 32'hFF, 32'd3};
        vt[3] = '{1'b1, 8'h85, 1'b0, 0, 32'h05, 32'd1};
        vt[4] = '{1'b0, 8'h1B, 1'b0, 2, 32'h05, 32'd2};
        vt[5] = '{1'b0, 8'h43, 1'b0, 0, 32'h05, 32'd3};
        vt[6] = '{1'b0, 8'h43, 1'b1, 0, 32'h05, 32'd5};
        for (int n = 0; n < 7; n++) begin
            if (vt[n].rst) do_reset();
            run_instr(vt[n].ins, vt[n].f, 1, 32'h0, held);
            case (vt[n].sel)
                1:       act = dut.i_r;
                2:       act = bus.alu_a;
                default: act = bus.alu_op;
            endcase
            chk($sformatf("vec%0d_val", n), act, vt[n].exp_val);
            chk($sformatf("vec%0d_pc", n), bus.cnt_pc, vt[n].exp_pc);
        end

        // RAM read with a three-cycle acknowledge, then a stall window
        do_reset();
        run_instr(8'h90, 1'b0, 1, 32'h0, held);
        run_instr(8'h0B, 1'b0, 1, 32'h0, held);
        run_instr(8'h32, 1'b0, 3, 32'hDEADBEEF, held);
        chk("ram_rd_held", held, 32'd3);
        chk("ram_rd_j", dut.j_r, 32'hDEADBEEF);
        chk("ram_rd_pc", bus.cnt_pc, 32'd3);
        idle(4);
        chk("stall_pc", bus.cnt_pc, 32'd3);

        // RAM-to-RAM reads only
        run_instr(8'h12, 1'b0, 2, 32'h12345678, held);
        chk("r2r_held", held, 32'd2);

        // Halt at PC 7, frozen until reset
        do_reset();
        for (int n = 0; n < 7; n++) run_instr(8'h3D, 1'b0, 1, 32'h0, held);
        run_instr(8'h00, 1'b0, 1, 32'h0, held);
        for (int n = 0; n < 10; n++) begin
            run_instr(8'($urandom_range(1, 255)), 1'($urandom()), 1, 32'h0, held);
            chk("halt_flag", {31'd0, bus.halted}, 32'd1);
            chk("halt_pc", bus.cnt_pc, 32'd7);
        end
        do_reset();
        chk("halt_rst_flag", {31'd0, bus.halted}, 32'd0);
        chk("halt_rst_pc", bus.cnt_pc, 32'd0);

        // Immediate overflow truncation and PC wrap
        for (int n = 0; n < 5; n++) run_instr(8'hFF, 1'b0, 1, 32'h0, held);
        chk("imm_trunc", bus.alu_op, 32'hFFFFFFFF);
        run_instr(8'h03, 1'b0, 1, 32'h0, held);
        chk("wrap_pc_max", bus.cnt_pc, 32'hFFFFFFFF);
        run_instr(8'h28, 1'b0, 1, 32'h0, held);
        chk("wrap_i", dut.i_r, 32'hFFFFFFFF);
        chk("wrap_pc_zero", bus.cnt_pc, 32'h0);

        // Reset while a RAM write is pending
        do_reset();
        run_instr(8'hAA, 1'b0, 1, 32'h0, held);
        run_instr(8'h2B, 1'b0, 1, 32'h0, held);
        bus.irom_in = 8'h15;
        bus.irom_valid = 1'b1;
        @(posedge clk); #1;
        bus.irom_valid = 1'b0;
        chk("rstmem_we", {31'd0, bus.dram_we}, 32'd1);
        chk("rstmem_wdata", bus.dram_wdata, 32'h2A);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_reset();
        chk("rstmem_we_off", {31'd0, bus.dram_we}, 32'd0);
        chk("rstmem_state", {30'd0, dut.state_r}, {30'd0, ST_RUN});
        cmp_all("rstmem");
        idle(2);

        // Random programs against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                idle($urandom_range(1, 3));
            end else begin
                ins = 8'($urandom());
                if (ins == 8'h00) ins = 8'h01;
                run_instr(ins, 1'($urandom()), $urandom_range(1, 4), $urandom(), held);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcpu2_core.md
MCPU2_CORE -- requirements
Module: mcpu2_core

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning width of all data registers, PC and buses (minimum 8).
REQ-002 The block SHALL have parameter RESET_PC, default 0, meaning the PC value loaded on reset.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have port cnt_pc, output, DATA_WIDTH, the instruction ROM address.
REQ-006 The block SHALL have ports irom_in, input, 8, the instruction byte, and irom_valid, input, 1, meaning irom_in is valid this cycle.
REQ-007 The block SHALL have ports dram_addr, output, DATA_WIDTH, RAM address; dram_wdata, output, DATA_WIDTH; dram_rdata, input, DATA_WIDTH.
REQ-008 The block SHALL have ports dram_re and dram_we, output, 1 each, RAM requests, and dram_ack, input, 1, completion of the current request.
REQ-009 The block SHALL have ports alu_a, alu_b and alu_op, output, DATA_WIDTH each, driven from the ALU_A, ALU_B and IMM registers.
REQ-010 The block SHALL have ports alu_d, input, DATA_WIDTH, ALU result, and alu_f, input, 1, ALU flag.
REQ-011 The block SHALL have port halted, output, 1, high while in HALT.

Function
REQ-012 Encoding SHALL be: bit7=IMM, bits6:0=immediate; else bit6=COND, bits5:3=dst, bits2:0=src; src/dst code order PC,ADDR,RAM,IMM/ALU_A,ALU/ALU_B,I,J,K.
REQ-013 The FSM SHALL have states RUN, MEM and HALT; reset enters RUN.
REQ-014 In RUN with irom_valid=0 the block SHALL change no state and assert no request.
REQ-015 IMM SHALL set IMM = {IMM[DATA_WIDTH-8:0], imm7} if the previous executed instruction was IMM, else zero-extended imm7; it SHALL then set last_imm=1 and PC=PC+1.
REQ-016 Any non-IMM instruction SHALL clear last_imm, including a COND instruction whose condition is false.
REQ-017 execute SHALL be 1 for MOV and alu_f, sampled in the decode cycle, for CMOV; execute=0 SHALL give PC+1 only.
REQ-018 Executed MOV without RAM SHALL complete in one cycle: dst <= src value; PC <= value if dst=PC, else PC+1.
REQ-019 Source PC SHALL read the address of the current instruction; source ALU SHALL read alu_d.
REQ-020 Executed MOV with src or dst RAM SHALL enter MEM next cycle with registered dram_addr=ADDR, dram_re (src RAM) or dram_we (dst RAM), and dram_wdata=source value, held stable until dram_ack.
REQ-021 In MEM with dram_ack=1 the block SHALL drop requests, write dram_rdata to dst if src RAM, PC <= dram_rdata if dst=PC else PC+1, and return to RUN; ack is ignored outside MEM.
REQ-022 RAM-to-RAM (src=dst=RAM) SHALL perform a read transaction only, discard the data, and assert no write.
REQ-023 irom_in=0x00 in RUN with irom_valid=1 SHALL enter HALT; HALT SHALL hold all state with PC frozen until reset.
REQ-024 PC SHALL wrap from 2^DATA_WIDTH-1 to 0; IMM shifting SHALL discard bits above DATA_WIDTH.

Reset
REQ-025 Reset SHALL set cnt_pc=RESET_PC and ADDR, IMM, ALU_A, ALU_B, I, J, K, last_imm, dram_re, dram_we, dram_wdata and halted to 0.
REQ-026 Reset SHALL override all states including MEM (pending request aborted, deasserted next cycle) and HALT.

Structure
REQ-027 Opcode field positions, src/dst codes and FSM state encodings SHALL be defined in a shared package/header mcpu2_defs.
REQ-028 Instruction decode (fields, execute, mem_op, halt) SHALL be a combinational sub-module mcpu2_decode; registers and FSM stay in mcpu2_core.

Verification
REQ-029 Reset, then IMM 0x01, IMM 0x7F, MOV I<-IMM -> I=0x0FF, cnt_pc=3.
REQ-030 IMM 0x05, MOV ALU_A<-IMM, CMOV PC<-IMM with alu_f=0 -> PC=3, no jump; repeat with alu_f=1 -> PC=0x05.
REQ-031 ADDR=0x10, MOV J<-RAM, ack after 3 MEM cycles with rdata=0xDEADBEEF -> dram_re held 3 cycles, J=0xDEADBEEF, PC advanced once.
REQ-032 irom_valid=0 for 4 cycles mid-program -> cnt_pc and all registers unchanged, no requests.
REQ-033 Opcode 0x00 at PC=7 -> halted=1, cnt_pc=7 for 10 cycles; reset -> halted=0, cnt_pc=RESET_PC.
REQ-034 Reset asserted in MEM during MOV RAM<-I -> dram_we=0 next cycle, state RUN, no write completed.
